bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_arb_pkg.sv | 14 +
 rtl/bram_port_arbiter_rr.sv | 31 +++
 rtl/bram_port_arbiter.sv | 107 ++++++++++
 tb/tb_bram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package bram_arb_pkg;
  localparam int MAX_NUM_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bram_port_arbiter_rr.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) among NUM_REQ requesters,
// round-robin, with one transaction in flight at a time.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wrdata,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic                              bram_clk,
  output logic                              bram_rst,
  output logic                              bram_en,
  output logic [DATA_WIDTH/8-1:0]           bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]        bram_addr,
  output logic [DATA_WIDTH-1:0]             bram_wrdata,
  input  logic [DATA_WIDTH-1:0]             bram_rddata
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int IW = idx_w(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        ptr_q, win_q;
  logic                 wr_q, first_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any, grant;
  logic                 g_write;
  logic [SW-1:0]        g_strb;

  assign bram_clk = aclk;
  assign bram_rst = !aresetn;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign g_write = req_write[arb_idx];
  assign g_strb  = req_strb[arb_idx*SW +: SW];
  // Grant is combinational, so it must also be masked while reset is held.
  assign grant   = (state_q == IDLE) && aresetn && arb_any;

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    bram_en     = 1'b0;
    bram_we     = '0;
    bram_addr   = req_addr[arb_idx*AW +: AW];
    bram_wrdata = req_wrdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    case (state_q)
      IDLE: begin
        if (grant) begin
          req_ready = arb_gnt;
          bram_en   = !g_write || (|g_strb);
          bram_we   = g_write ? g_strb : '0;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid[win_q] = 1'b1;
        // First response cycle sees BRAM output directly; later cycles the hold copy.
        rsp_data = wr_q ? '0 : (first_q ? bram_rddata : hold_q);
        if (rsp_ready[win_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      first_q <= grant;
      if (grant) begin
        win_q <= arb_idx;
        wr_q  <= g_write;
        ptr_q <= (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + IW'(1);
      end
      if (first_q && !wr_q) hold_q <= bram_rddata;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized and directed bench for bram_port_arbiter with a queue-free behavioural model.
module tb_bram_port_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [N*SW-1:0]   req_strb;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wrdata;
  logic [DW-1:0]     rsp_data;
  logic              bram_clk, bram_rst, bram_en;
  logic [SW-1:0]     bram_we;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_wrdata, bram_rddata;

  logic [DW-1:0]     bmem    [0:255];
  logic [DW-1:0]     ref_mem [0:255];
  logic [DW-1:0]     rd_q, noise_val, poke_val;
  logic [7:0]        poke_addr;
  logic              poke_en, noise;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 aclk = ~aclk;

  bram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_strb(req_strb),
    .req_write(req_write), .req_addr(req_addr), .req_wrdata(req_wrdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  // Simple read-first BRAM, 1-cycle read latency.
  always @(posedge aclk) begin
    if (poke_en) bmem[poke_addr] <= poke_val;
    else if (bram_en) begin
      rd_q <= bmem[bram_addr[7:0]];
      for (int b = 0; b < SW; b++)
        if (bram_we[b]) bmem[bram_addr[7:0]][8*b +: 8] <= bram_wrdata[8*b +: 8];
    end
  end
  assign bram_rddata = noise ? noise_val : rd_q;

  task automatic clear_reqs();
    req_valid = '0; req_write = '0; req_strb = '0; req_addr = '0; req_wrdata = '0;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [SW-1:0] s,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r] = 1'b1; req_write[r] = wr; req_strb[r*SW +: SW] = s;
    req_addr[r*AW +: AW] = a; req_wrdata[r*DW +: DW] = d;
  endtask

  task automatic poke(input logic [7:0] a, input logic [DW-1:0] v);
    poke_en = 1'b1; poke_addr = a; poke_val = v; ref_mem[a] = v;
    @(posedge aclk); #1;
    poke_en = 1'b0;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; clear_reqs(); req_valid = '1; rsp_ready = '1;
    repeat (2) @(posedge aclk); #1;
    chk_cnt++; if (req_ready !== 3'b000) $display("FAIL reset_req_ready got=%b exp=000", req_ready); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid); else pass_cnt++;
    chk_cnt++; if (bram_en !== 1'b0) $display("FAIL reset_bram_en got=%b exp=0", bram_en); else pass_cnt++;
    chk_cnt++; if (bram_we !== 4'h0) $display("FAIL reset_bram_we got=%h exp=0", bram_we); else pass_cnt++;
    chk_cnt++; if (bram_rst !== 1'b1) $display("FAIL reset_bram_rst got=%b exp=1", bram_rst); else pass_cnt++;
    chk_cnt++; if (bram_clk !== aclk) $display("FAIL bram_clk got=%b exp=%b", bram_clk, aclk); else pass_cnt++;
    clear_reqs(); aresetn = 1'b1; #1;
    chk_cnt++; if (bram_rst !== 1'b0) $display("FAIL release_bram_rst got=%b exp=0", bram_rst); else pass_cnt++;
  endtask

  task automatic test_read();
    poke(8'h10, 32'hDEADBEEF);
    rsp_ready = '1; set_req(0, 1'b0, 4'h0, 16'h0010, 32'h0); #1;
    chk_cnt++; if (req_ready !== 3'b001) $display("FAIL read_grant got=%b exp=001", req_ready); else pass_cnt++;
    chk_cnt++; if (bram_en !== 1'b1) $display("FAIL read_en got=%b exp=1", bram_en); else pass_cnt++;
    chk_cnt++; if (bram_addr !== 16'h0010) $display("FAIL read_addr got=%h exp=0010", bram_addr); else pass_cnt++;
    chk_cnt++; if (bram_we !== 4'h0) $display("FAIL read_we got=%h exp=0", bram_we); else pass_cnt++;
    @(posedge aclk); #1 clear_reqs(); #1;
    chk_cnt++; if (rsp_valid !== 3'b001) $display("FAIL read_rsp_valid got=%b exp=001", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL read_rsp_data got=%h exp=deadbeef", rsp_data); else pass_cnt++;
    @(posedge aclk); #1;
    chk_cnt++; if (rsp_valid !== 3'b000) $display("FAIL read_rsp_done got=%b exp=000", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    rsp_ready = '0; set_req(0, 1'b0, 4'h0, 16'h0010, 32'h0); #1;
    chk_cnt++; if (req_ready !== 3'b001) $display("FAIL bp_grant got=%b exp=001", req_ready); else pass_cnt++;
    @(posedge aclk); #1 clear_reqs(); #1;
    chk_cnt++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL bp_data_c1 got=%h exp=deadbeef", rsp_data); else pass_cnt++;
    for (int c = 2; c <= 6; c++) begin
      @(posedge aclk); #1;
      noise = 1'b1; noise_val = $urandom | 32'h1;
      if (c == 6) rsp_ready[0] = 1'b1;
      #1;
      chk_cnt++; if (rsp_valid !== 3'b001) $display("FAIL bp_valid_c%0d got=%b exp=001", c, rsp_valid); else pass_cnt++;
      chk_cnt++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL bp_data_c%0d got=%h exp=deadbeef", c, rsp_data); else pass_cnt++;
    end
    @(posedge aclk); #1 noise = 1'b0; #1;
    chk_cnt++; if (rsp_valid !== 3'b000) $display("FAIL bp_done got=%b exp=000", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_contention();
    int seen [2];
    logic [N-1:0] exp_oh;
    seen[0] = 0; seen[1] = 0;
    apply_reset();
    rsp_ready = '1; clear_reqs();
    set_req(0, 1'b0, 4'h0, 16'h0010, 32'h0);
    set_req(1, 1'b0, 4'h0, 16'h0011, 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_oh = '0; exp_oh[k % 2] = 1'b1;
      #1;
      chk_cnt++; if (req_ready !== exp_oh) $display("FAIL cont_grant%0d got=%b exp=%b", k, req_ready, exp_oh); else pass_cnt++;
      if (req_ready[0]) seen[0]++;
      if (req_ready[1]) seen[1]++;
      @(posedge aclk); #2;
      chk_cnt++; if (rsp_valid !== exp_oh) $display("FAIL cont_rsp%0d got=%b exp=%b", k, rsp_valid, exp_oh); else pass_cnt++;
      chk_cnt++; if (req_ready !== 3'b000) $display("FAIL cont_resp_ready%0d got=%b exp=000", k, req_ready); else pass_cnt++;
      chk_cnt++; if (rsp_data !== ref_mem[8'h10 + 8'(k % 2)]) $display("FAIL cont_data%0d got=%h exp=%h", k, rsp_data, ref_mem[8'h10 + 8'(k % 2)]); else pass_cnt++;
      @(posedge aclk); #1;
    end
    chk_cnt++; if (seen[0] != 4 || seen[1] != 4) $display("FAIL cont_fair got=%0d,%0d exp=4,4", seen[0], seen[1]); else pass_cnt++;
    clear_reqs();
  endtask

  task automatic test_write_readback();
    poke(8'h20, 32'hAAAAAAAA);
    rsp_ready = '1; set_req(1, 1'b1, 4'b0011, 16'h0020, 32'h12345678); #1;
    chk_cnt++; if (req_ready !== 3'b010) $display("FAIL wr_grant got=%b exp=010", req_ready); else pass_cnt++;
    chk_cnt++; if (bram_en !== 1'b1 || bram_we !== 4'b0011) $display("FAIL wr_en_we got=%b/%b exp=1/0011", bram_en, bram_we); else pass_cnt++;
    chk_cnt++; if (bram_wrdata !== 32'h12345678) $display("FAIL wr_data got=%h exp=12345678", bram_wrdata); else pass_cnt++;
    @(posedge aclk); #1 clear_reqs(); #1;
    chk_cnt++; if (rsp_valid !== 3'b010 || rsp_data !== 32'h0) $display("FAIL wr_rsp got=%b/%h exp=010/0", rsp_valid, rsp_data); else pass_cnt++;
    @(posedge aclk); #1 set_req(1, 1'b0, 4'h0, 16'h0020, 32'h0);
    @(posedge aclk); #1 clear_reqs(); #1;
    chk_cnt++; if (rsp_data !== 32'hAAAA5678) $display("FAIL wr_readback got=%h exp=aaaa5678", rsp_data); else pass_cnt++;
    @(posedge aclk); #1;
  endtask

  task automatic test_zero_strobe();
    poke(8'h21, 32'h55AA55AA);
    rsp_ready = '1; set_req(2, 1'b1, 4'h0, 16'h0021, 32'hFFFFFFFF); #1;
    chk_cnt++; if (req_ready !== 3'b100) $display("FAIL zs_grant got=%b exp=100", req_ready); else pass_cnt++;
    chk_cnt++; if (bram_en !== 1'b0 || bram_we !== 4'h0) $display("FAIL zs_en_we got=%b/%h exp=0/0", bram_en, bram_we); else pass_cnt++;
    @(posedge aclk); #1 clear_reqs(); #1;
    chk_cnt++; if (rsp_valid !== 3'b100 || rsp_data !== 32'h0) $display("FAIL zs_rsp got=%b/%h exp=100/0", rsp_valid, rsp_data); else pass_cnt++;
    @(posedge aclk); #1 set_req(2, 1'b0, 4'h0, 16'h0021, 32'h0);
    @(posedge aclk); #1 clear_reqs(); #1;
    chk_cnt++; if (rsp_data !== 32'h55AA55AA) $display("FAIL zs_unchanged got=%h exp=55aa55aa", rsp_data); else pass_cnt++;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset_mid_resp();
    rsp_ready = '0; set_req(1, 1'b0, 4'h0, 16'h0010, 32'h0);
    @(posedge aclk); #1 clear_reqs(); #1;
    chk_cnt++; if (rsp_valid !== 3'b010) $display("FAIL mr_rsp_before got=%b exp=010", rsp_valid); else pass_cnt++;
    aresetn = 1'b0; #1;
    chk_cnt++; if (rsp_valid !== 3'b000) $display("FAIL mr_rsp_in_reset got=%b exp=000", rsp_valid); else pass_cnt++;
    @(posedge aclk); #1 aresetn = 1'b1;
    for (int r = 0; r < N; r++) set_req(r, 1'b0, 4'h0, 16'h0010, 32'h0);
    #1;
    chk_cnt++; if (rsp_valid !== 3'b000) $display("FAIL mr_no_rsp got=%b exp=000", rsp_valid); else pass_cnt++;
    chk_cnt++; if (req_ready !== 3'b001) $display("FAIL mr_ptr_reset got=%b exp=001", req_ready); else pass_cnt++;
    @(posedge aclk); #1 clear_reqs(); rsp_ready = '1; #1;
    chk_cnt++; if (rsp_valid !== 3'b001) $display("FAIL mr_new_rsp got=%b exp=001", rsp_valid); else pass_cnt++;
    @(posedge aclk); #1;
  endtask

  task automatic test_random();
    bit m_busy; int m_ptr, m_win, g;
    logic [DW-1:0] m_data;
    logic [N-1:0] exp_ready, exp_rv;
    logic exp_en; logic [SW-1:0] exp_we, s; logic [AW-1:0] a; logic wr;
    apply_reset();
    m_busy = 0; m_ptr = 0; m_win = 0; m_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < N; r++) begin
        req_valid[r] = ($urandom_range(0, 9) < 6);
        req_write[r] = $urandom_range(0, 1);
        req_strb[r*SW +: SW] = ($urandom_range(0, 3) == 0) ? 4'h0 : SW'($urandom);
        req_addr[r*AW +: AW] = AW'($urandom_range(0, 31));
        req_wrdata[r*DW +: DW] = $urandom;
        rsp_ready[r] = ($urandom_range(0, 9) < 7);
      end
      #1;
      exp_ready = '0; exp_rv = '0; exp_en = 1'b0; exp_we = '0; g = -1; wr = 1'b0; s = '0; a = '0;
      if (!m_busy)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        wr = req_write[g]; s = req_strb[g*SW +: SW]; a = req_addr[g*AW +: AW];
        exp_en = !(wr && s == 0);
        exp_we = wr ? s : '0;
      end
      if (m_busy) exp_rv[m_win] = 1'b1;
      chk_cnt++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, req_ready, exp_ready); else pass_cnt++;
      chk_cnt++; if (rsp_valid !== exp_rv) $display("FAIL rnd_rsp_valid c%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); else pass_cnt++;
      chk_cnt++; if (bram_en !== exp_en || bram_we !== exp_we) $display("FAIL rnd_en_we c%0d got=%b/%h exp=%b/%h", cyc, bram_en, bram_we, exp_en, exp_we); else pass_cnt++;
      if (g >= 0) begin
        chk_cnt++; if (bram_addr !== a) $display("FAIL rnd_addr c%0d got=%h exp=%h", cyc, bram_addr, a); else pass_cnt++;
      end
      if (m_busy) begin
        chk_cnt++; if (rsp_data !== m_data) $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, rsp_data, m_data); else pass_cnt++;
      end
      if (g >= 0) begin
        m_busy = 1; m_win = g; m_ptr = (g + 1) % N;
        if (wr) begin
          m_data = '0;
          for (int b = 0; b < SW; b++)
            if (s[b]) ref_mem[a[7:0]][8*b +: 8] = req_wrdata[g*DW + 8*b +: 8];
        end else m_data = ref_mem[a[7:0]];
      end else if (m_busy && rsp_ready[m_win]) m_busy = 0;
      @(posedge aclk); #1;
    end
    clear_reqs(); rsp_ready = '1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; noise = 1'b0; noise_val = '0; poke_en = 1'b0; poke_addr = '0; poke_val = '0;
    clear_reqs(); rsp_ready = '0;
    for (int i = 0; i < 32; i++) poke(8'(i), $urandom);
    test_reset();
    test_read();
    test_backpressure();
    test_contention();
    test_write_readback();
    test_zero_strobe();
    test_reset_mid_resp();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
